// File: rtl/tms_pmem_arbiter.sv
// TMS1x00 program-memory arbiter: sequences load -> start -> run and shares the
// single-port program memory between core fetches and Wishbone host accesses.
module tms_pmem_arbiter #(
  parameter int ADDR_W     = 11,
  parameter int DATA_W     = 8,
  parameter int RST_CYCLES = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_n,
  input  logic              ctrl_run_i,
  input  logic              wb_cyc_i,
  input  logic              wb_stb_i,
  input  logic              wb_we_i,
  input  logic [ADDR_W-1:0] wb_adr_i,
  input  logic [DATA_W-1:0] wb_dat_i,
  output logic              wb_ack_o,
  output logic [DATA_W-1:0] wb_dat_o,
  input  logic              core_req_i,
  input  logic [ADDR_W-1:0] core_addr_i,
  output logic              core_valid_o,
  output logic [DATA_W-1:0] core_rdata_o,
  output logic              core_rst_n_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic [1:0]        state_o,
  output logic [ADDR_W:0]   wr_count_o,
  output logic              prot_err_o
);

  // state | meaning
  // LOAD  | core held in reset, host owns memory, writes land in memory
  // START | core reset held for RST_CYCLES cycles, host served, writes blocked
  // RUN   | core fetches have priority, host bounded by the starvation guard
  typedef enum logic [1:0] {LOAD = 2'd0, START = 2'd1, RUN = 2'd2} state_t;

  localparam logic [ADDR_W:0] WR_MAX = {1'b1, {ADDR_W{1'b0}}};

  state_t          state;
  logic [3:0]      rst_tmr;
  logic [3:0]      starve_cnt;
  logic            ack;
  logic            rd_q;
  logic            valid;
  logic            core_rst_n;
  logic [ADDR_W:0] wr_count;
  logic            prot_err;

  logic host_pend, leaving, force_host, host_gnt, core_gnt, host_wr, mem_wr_ok;

  // The cycle that leaves START/RUN grants no host slot, so a pending write
  // lands in LOAD instead of being rejected and then forgotten.
  always_comb begin
    host_pend  = wb_cyc_i & wb_stb_i & ~ack;
    leaving    = (state != LOAD) & ~ctrl_run_i;
    force_host = (starve_cnt == 4'(STARVE_MAX));
    host_gnt   = 1'b0;
    core_gnt   = 1'b0;
    if (wb_rst_n) begin
      case (state)
        LOAD:  host_gnt = host_pend;
        START: host_gnt = host_pend & ctrl_run_i;
        RUN: begin
          host_gnt = host_pend & ctrl_run_i & (force_host | ~core_req_i);
          core_gnt = core_req_i & ~host_gnt;
        end
        default: host_gnt = 1'b0;
      endcase
    end
    host_wr   = host_gnt & wb_we_i;
    mem_wr_ok = host_wr & (state == LOAD);
  end

  assign mem_en_o     = core_gnt | (host_gnt & (~wb_we_i | (state == LOAD)));
  assign mem_we_o     = mem_wr_ok;
  assign mem_addr_o   = host_gnt ? wb_adr_i : core_addr_i;
  assign mem_wdata_o  = wb_dat_i;

  assign wb_ack_o     = ack;
  assign wb_dat_o     = rd_q ? mem_rdata_i : '0;
  assign core_valid_o = valid;
  assign core_rdata_o = valid ? mem_rdata_i : '0;
  assign core_rst_n_o = core_rst_n;
  assign state_o      = state;
  assign wr_count_o   = wr_count;
  assign prot_err_o   = prot_err;

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state      <= LOAD;
      rst_tmr    <= '0;
      starve_cnt <= '0;
      ack        <= 1'b0;
      rd_q       <= 1'b0;
      valid      <= 1'b0;
      core_rst_n <= 1'b0;
      wr_count   <= '0;
      prot_err   <= 1'b0;
    end else begin
      ack   <= host_gnt;
      rd_q  <= host_gnt & ~wb_we_i;
      valid <= core_gnt;
      if (mem_wr_ok && wr_count != WR_MAX) wr_count <= wr_count + 1'b1;
      if (host_wr && state != LOAD) prot_err <= 1'b1;
      if (state != RUN || leaving || host_gnt) starve_cnt <= '0;
      else if (host_pend) starve_cnt <= starve_cnt + 1'b1;

      case (state)
        LOAD: begin
          if (ctrl_run_i) begin
            state   <= START;
            rst_tmr <= 4'(RST_CYCLES - 1);
          end
        end
        START: begin
          if (!ctrl_run_i) begin
            state    <= LOAD;
            wr_count <= '0;
            prot_err <= 1'b0;
          end else if (rst_tmr == 4'd0) begin
            state      <= RUN;
            core_rst_n <= 1'b1;
          end else begin
            rst_tmr <= rst_tmr - 1'b1;
          end
        end
        RUN: begin
          if (!ctrl_run_i) begin
            state      <= LOAD;
            core_rst_n <= 1'b0;
            wr_count   <= '0;
            prot_err   <= 1'b0;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: doc/tms_pmem_arbiter.md
Name: tms_pmem_arbiter

Overview:
- Sits inside the TMS1x00 user-project wrapper, between the Wishbone slave path and the core's instruction-fetch port.
- Owns the single-port program memory and sequences the load → start → run lifecycle.
- Holds the core in reset while the host loads the program, releases it after a fixed delay, and then arbitrates memory between core fetches and host reads.
- Host starvation is bounded by a starvation guard.

Parameters:
ADDR_W, 11, program memory word-address width (2048 bytes)
DATA_W, 8, program memory word width
RST_CYCLES, 4, cycles the core reset is held low in START before entering RUN (range 1..15)
STARVE_MAX, 8, consecutive denied cycles after which the pending host access wins one slot (range 1..15)

Ports:
wb_clk_i  in  1  clock
wb_rst_n  in  1  asynchronous active-low reset
ctrl_run_i  in  1  level; 1 = run program, 0 = load mode
wb_cyc_i  in  1  Wishbone cycle
wb_stb_i  in  1  Wishbone strobe (memory-space select already decoded upstream)
wb_we_i  in  1  Wishbone write enable
wb_adr_i  in  ADDR_W  word address
wb_dat_i  in  DATA_W  write data
wb_ack_o  out  1  single-cycle acknowledge
wb_dat_o  out  DATA_W  read data, valid with ack
core_req_i  in  1  core fetch request (level; one read per granted cycle)
core_addr_i  in  ADDR_W  fetch address
core_valid_o  out  1  fetch data valid
core_rdata_o  out  DATA_W  fetch data
core_rst_n_o  out  1  core reset, active-low
mem_en_o  out  1  memory enable
mem_we_o  out  1  memory write enable
mem_addr_o  out  ADDR_W  memory address
mem_wdata_o  out  DATA_W  memory write data
mem_rdata_i  in  DATA_W  memory read data, 1 cycle after mem_en_o with mem_we_o=0
state_o  out  2  0=LOAD 1=START 2=RUN
wr_count_o  out  ADDR_W+1  host writes accepted since last LOAD entry, saturating
prot_err_o  out  1  sticky: host write attempted in START/RUN

Behaviour:
- Reset values: state LOAD; core_rst_n_o=0; wb_ack_o=0; core_valid_o=0; wr_count_o=0; prot_err_o=0; wb_dat_o=0; core_rdata_o=0; starvation counter 0.
- mem_* outputs are combinational from the arbitration decision in cycle N.
- wb_ack_o, core_valid_o and the read data are registered and appear in cycle N+1, taking mem_rdata_i.
- Host pending condition: wb_cyc_i & wb_stb_i & !wb_ack_o. In the ack cycle no new host grant is issued, which prevents a double access.
- LOAD:
  - core_rst_n_o=0; the host owns the memory; core_req_i is ignored.
  - Each pending host access is granted immediately; ack follows in N+1.
  - Every accepted write increments wr_count_o, saturating at 2^ADDR_W.
  - Transition to START when ctrl_run_i=1.
- START:
  - core_rst_n_o stays 0 for RST_CYCLES cycles, counted from START entry, then the state goes to RUN. core_rst_n_o is registered high on the first RUN cycle.
  - Host accesses are served as in RUN, with no core competing.
  - ctrl_run_i=0 returns the state to LOAD.
- RUN:
  - The core has priority: if core_req_i=1, the core is granted; otherwise a pending host access is granted.
  - Starvation counter increments each cycle the host is pending but denied, and clears on a host grant.
  - When the counter reaches STARVE_MAX, the next cycle grants the host even if core_req_i=1. The core sees no core_valid_o for that slot and must hold its request.
  - ctrl_run_i=0 transitions to LOAD next cycle; core_rst_n_o goes 0 on that edge.
- Host writes in START/RUN: acked normally, but mem_we_o stays 0 (the slot performs no memory access), wr_count_o is unchanged, and prot_err_o is set.
- Host reads in any state: return memory data.
- LOAD entry from RUN/START clears wr_count_o and prot_err_o.
- A core read granted in the last RUN cycle still yields core_valid_o in the first LOAD cycle. This is harmless because the core is already in reset.
- Simultaneous ctrl_run_i fall and STARVE_MAX hit: the LOAD transition takes precedence, and the pending host access is granted in LOAD.
- Asynchronous reset mid-transaction: all outputs return to reset values immediately, and any in-flight ack is dropped.

Test Plan:
- Write 0xA5 to addr 0x000, 0x3C to 0x7FF in LOAD, then read both back → ack one cycle after each grant; reads return A5/3C; wr_count_o=2; core_rst_n_o stays 0.
- ctrl_run_i 0→1 → state_o=1 for exactly 4 cycles; core_rst_n_o rises on the first RUN cycle.
- RUN, core_req_i held high at addr 0x010 (mem holds 0x5E), host read pending → host served exactly once after 8 denied cycles; core_valid_o low only in that slot; all other core data = 0x5E.
- RUN, host write 0xFF to 0x000 → ack returned, mem_we_o never asserted, prot_err_o=1, subsequent read of 0x000 returns 0xA5.
- ctrl_run_i drops in RUN with host write pending and STARVE_MAX reached on the same cycle → next state LOAD, core_rst_n_o=0, prot_err_o cleared, the write is performed, wr_count_o=1.
- Assert wb_rst_n low during a LOAD write grant → no ack; all outputs return to reset values; state_o=0.
